wb_bus_arbiter: RTL and testbench

WB_BUS_ARBITER -- requirements
Module: wb_bus_arbiter

---
 rtl/wb_bus_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter.sv
// Two-requester Wishbone bus arbiter with fair alternation on contention
// and a watchdog that aborts an owned cycle the slave never answers.
package wb_pkg;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic [1:0]  bte;
    } wb_master_t;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic        rty;
        logic        stall;
        logic [31:0] dat;
    } wb_slave_t;

endpackage

module wb_bus_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  wb_master_t wb_m0_i,
    output wb_slave_t  wb_m0_o,
    input  wb_master_t wb_m1_i,
    output wb_slave_t  wb_m1_o,
    output wb_master_t wb_m_o,
    input  wb_slave_t  wb_s_i,
    output logic [1:0] grant_o,
    output logic       timeout_o
);

    localparam int unsigned CW =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);
    localparam logic WD_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        IDLE,
        OWN0,
        OWN1,
        ABORT,
        RELEASE
    } state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic          own_q, own_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic own_cyc;
    logic oth_cyc;
    logic resp;
    logic wd_hit;

    assign own_cyc = own_q ? wb_m1_i.cyc : wb_m0_i.cyc;
    assign oth_cyc = own_q ? wb_m0_i.cyc : wb_m1_i.cyc;
    assign resp    = wb_s_i.ack | wb_s_i.err | wb_s_i.rty;
    assign wd_hit  = WD_EN && (cnt_q == TO_LIM) && !resp;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            own_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter defaults to zero, so any entry into OWNn starts it fresh.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        own_d   = own_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (wb_m0_i.cyc && wb_m1_i.cyc) begin
                    own_d   = ~last_q;
                    state_d = last_q ? OWN0 : OWN1;
                end else if (wb_m0_i.cyc) begin
                    own_d   = 1'b0;
                    state_d = OWN0;
                end else if (wb_m1_i.cyc) begin
                    own_d   = 1'b1;
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!own_cyc) begin
                    last_d = own_q;
                    if (oth_cyc) begin
                        own_d   = ~own_q;
                        state_d = own_q ? OWN0 : OWN1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wd_hit) begin
                    state_d = ABORT;
                end else if (!resp) begin
                    cnt_d = (cnt_q == TO_LIM) ? cnt_q : cnt_q + 1'b1;
                end
            end
            ABORT: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!own_cyc) begin
                    last_d  = own_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wb_m_o        = '0;
        wb_m0_o       = '0;
        wb_m0_o.stall = 1'b1;
        wb_m0_o.dat   = wb_s_i.dat;
        wb_m1_o       = '0;
        wb_m1_o.stall = 1'b1;
        wb_m1_o.dat   = wb_s_i.dat;
        grant_o       = 2'b00;
        timeout_o     = 1'b0;
        unique case (state_q)
            OWN0: begin
                wb_m_o        = wb_m0_i;
                wb_m0_o.ack   = wb_s_i.ack;
                wb_m0_o.err   = wb_s_i.err;
                wb_m0_o.rty   = wb_s_i.rty;
                wb_m0_o.stall = wb_s_i.stall;
                grant_o       = 2'b01;
            end
            OWN1: begin
                wb_m_o        = wb_m1_i;
                wb_m1_o.ack   = wb_s_i.ack;
                wb_m1_o.err   = wb_s_i.err;
                wb_m1_o.rty   = wb_s_i.rty;
                wb_m1_o.stall = wb_s_i.stall;
                grant_o       = 2'b10;
            end
            ABORT: begin
                timeout_o = 1'b1;
                grant_o   = own_q ? 2'b10 : 2'b01;
                if (own_q) begin
                    wb_m1_o.err   = 1'b1;
                    wb_m1_o.stall = 1'b0;
                end else begin
                    wb_m0_o.err   = 1'b1;
                    wb_m0_o.stall = 1'b0;
                end
            end
            RELEASE: begin
                grant_o = own_q ? 2'b10 : 2'b01;
            end
            default: begin
                grant_o = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: a transaction-level ownership model
// checked every cycle, plus literal checks for the key scenarios.
module tb_wb_bus_arbiter;
    import wb_pkg::*;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    wb_master_t m0, m1, bus;
    wb_slave_t  s, r0, r1;
    logic [1:0] grant;
    logic       tmo;

    int n_chk = 0;
    int n_fail = 0;
    int ack0 = 0;
    int ack1 = 0;
    int glog[$];
    logic [1:0] prev_g = 2'b00;

    // Model: who owns the bus, in which phase, and the watchdog count.
    int md_own = -1;
    bit md_abort = 1'b0;
    bit md_rel = 1'b0;
    int md_last = 1;
    int md_wd = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    wb_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .wb_m0_i  (m0),
        .wb_m0_o  (r0),
        .wb_m1_i  (m1),
        .wb_m1_o  (r1),
        .wb_m_o   (bus),
        .wb_s_i   (s),
        .grant_o  (grant),
        .timeout_o(tmo)
    );

    task automatic chk(input string nm, input logic [127:0] a,
                       input logic [127:0] x);
        n_chk++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, x, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
        #1;
    endtask

    always @(posedge clk) begin : model
        int own_n, wd_n, last_n;
        bit ab_n, rel_n, resp;
        bit c[2];
        c[0] = m0.cyc;
        c[1] = m1.cyc;
        resp = s.ack | s.err | s.rty;
        own_n = md_own;
        wd_n = md_wd;
        last_n = md_last;
        ab_n = 1'b0;
        rel_n = md_rel;
        if (!rst_n) begin
            own_n = -1;
            wd_n = 0;
            last_n = 1;
            rel_n = 1'b0;
        end else if (md_own < 0) begin
            if (c[0] && c[1]) own_n = 1 - md_last;
            else if (c[0]) own_n = 0;
            else if (c[1]) own_n = 1;
            wd_n = 0;
        end else if (md_abort) begin
            rel_n = 1'b1;
        end else if (md_rel) begin
            if (!c[md_own]) begin
                last_n = md_own;
                own_n = -1;
                rel_n = 1'b0;
            end
        end else if (!c[md_own]) begin
            last_n = md_own;
            own_n = c[1 - md_own] ? 1 - md_own : -1;
            wd_n = 0;
        end else if (md_wd == TO && !resp) begin
            ab_n = 1'b1;
        end else begin
            wd_n = resp ? 0 : ((md_wd < TO) ? md_wd + 1 : TO);
        end
        md_own <= own_n;
        md_wd <= wd_n;
        md_last <= last_n;
        md_abort <= ab_n;
        md_rel <= rel_n;
        started <= 1'b1;
    end

    always @(negedge clk) begin : cmp
        wb_master_t eb;
        wb_slave_t  e[2];
        logic [1:0] eg;
        logic       et;
        if (started) begin
            eb = '0;
            e[0] = '0;
            e[0].stall = 1'b1;
            e[0].dat = s.dat;
            e[1] = e[0];
            eg = 2'b00;
            et = 1'b0;
            if (md_own >= 0) begin
                eg = (md_own == 0) ? 2'b01 : 2'b10;
                if (md_abort) begin
                    et = 1'b1;
                    e[md_own].err = 1'b1;
                    e[md_own].stall = 1'b0;
                end else if (!md_rel) begin
                    eb = (md_own == 0) ? m0 : m1;
                    e[md_own].ack = s.ack;
                    e[md_own].err = s.err;
                    e[md_own].rty = s.rty;
                    e[md_own].stall = s.stall;
                end
            end
            chk("bus", 128'(bus), 128'(eb));
            chk("resp0", 128'(r0), 128'(e[0]));
            chk("resp1", 128'(r1), 128'(e[1]));
            chk("grant", 128'(grant), 128'(eg));
            chk("timeout", 128'(tmo), 128'(et));
        end
    end

    always @(negedge clk) begin
        if (r0.ack) ack0 <= ack0 + 1;
        if (r1.ack) ack1 <= ack1 + 1;
        if (grant != prev_g && grant != 2'b00)
            glog.push_back((grant == 2'b10) ? 1 : 0);
        prev_g <= grant;
    end

    initial begin
        logic [1:0] g;
        int a0, a1;
        m0 = '0;
        m1 = '0;
        s = '0;
        // Requests and a stray ack while held in reset
        m0.cyc = 1'b1;
        m0.stb = 1'b1;
        s.ack = 1'b1;
        rst_n = 1'b0;
        tick;
        tick;
        at_neg;
        chk("rst_grant", 128'(grant), 128'(2'b00));
        chk("rst_bus", 128'(bus), 128'(0));
        chk("rst_stall0", 128'(r0.stall), 128'(1));
        chk("rst_ack0", 128'(r0.ack), 128'(0));
        chk("rst_tmo", 128'(tmo), 128'(0));
        tick;
        rst_n = 1'b1;
        m0 = '0;
        s = '0;
        tick;

        // Single read from m0
        m0.cyc = 1'b1;
        m0.stb = 1'b1;
        m0.adr = 32'h2000_0000;
        m0.sel = 4'hf;
        tick;
        at_neg;
        chk("s_grant", 128'(grant), 128'(2'b01));
        chk("s_adr", 128'(bus.adr), 128'(32'h2000_0000));
        chk("s_stall1", 128'(r1.stall), 128'(1));
        tick;
        tick;
        s.ack = 1'b1;
        s.dat = 32'hDEAD_BEEF;
        at_neg;
        chk("s_ack0", 128'(r0.ack), 128'(1));
        chk("s_dat0", 128'(r0.dat), 128'(32'hDEAD_BEEF));
        chk("s_ack1", 128'(r1.ack), 128'(0));
        tick;
        m0 = '0;
        s = '0;
        tick;
        at_neg;
        chk("s_idle", 128'(grant), 128'(2'b00));

        // Contention with 4-beat bursts after a fresh reset
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        a0 = ack0;
        a1 = ack1;
        m0.cyc = 1'b1;
        m0.stb = 1'b1;
        m0.cti = 3'b010;
        m0.adr = 32'h1000;
        m1.cyc = 1'b1;
        m1.stb = 1'b1;
        m1.cti = 3'b010;
        m1.adr = 32'h3000;
        tick;
        at_neg;
        chk("c_first", 128'(grant), 128'(2'b01));
        for (int b = 0; b < 4; b++) begin
            tick;
            s.ack = 1'b1;
            m0.adr = 32'h1000 + 32'(4 * b);
            m0.cti = (b == 3) ? 3'b111 : 3'b010;
        end
        tick;
        s.ack = 1'b0;
        m0 = '0;
        tick;
        at_neg;
        chk("c_handoff", 128'(grant), 128'(2'b10));
        for (int b = 0; b < 4; b++) begin
            tick;
            s.ack = 1'b1;
            m1.adr = 32'h3000 + 32'(4 * b);
            m1.cti = (b == 3) ? 3'b111 : 3'b010;
        end
        tick;
        s = '0;
        m1 = '0;
        tick;
        at_neg;
        chk("c_idle", 128'(grant), 128'(2'b00));
        chk("c_acks0", 128'(ack0 - a0), 128'(4));
        chk("c_acks1", 128'(ack1 - a1), 128'(4));

        // Back-to-back re-requests from both sides
        tick;
        glog.delete();
        m0.cyc = 1'b1;
        m0.stb = 1'b1;
        m1.cyc = 1'b1;
        m1.stb = 1'b1;
        tick;
        for (int t = 0; t < 6; t++) begin
            g = grant;
            s.ack = 1'b1;
            tick;
            s.ack = 1'b0;
            if (t == 5) begin
                m0 = '0;
                m1 = '0;
            end else if (g == 2'b01) begin
                m0.cyc = 1'b0;
                m0.stb = 1'b0;
            end else begin
                m1.cyc = 1'b0;
                m1.stb = 1'b0;
            end
            tick;
            if (t < 5) begin
                m0.cyc = 1'b1;
                m0.stb = 1'b1;
                m1.cyc = 1'b1;
                m1.stb = 1'b1;
            end
        end
        tick;
        at_neg;
        chk("f_count", 128'(glog.size()), 128'(6));
        for (int i = 0; i < 6; i++)
            chk("f_order", 128'((i < glog.size()) ? glog[i] : -1), 128'(i % 2));

        // Watchdog abort on m1 with a silent slave
        tick;
        m1.cyc = 1'b1;
        m1.stb = 1'b1;
        m1.adr = 32'h4000;
        tick;
        repeat (8) tick;
        at_neg;
        chk("t_pre", 128'(tmo), 128'(0));
        chk("t_pre_grant", 128'(grant), 128'(2'b10));
        tick;
        at_neg;
        chk("t_pulse", 128'(tmo), 128'(1));
        chk("t_err", 128'(r1.err), 128'(1));
        chk("t_stall", 128'(r1.stall), 128'(0));
        chk("t_cyc", 128'(bus.cyc), 128'(0));
        chk("t_grant", 128'(grant), 128'(2'b10));
        tick;
        s.ack = 1'b1;
        at_neg;
        chk("t_rel_tmo", 128'(tmo), 128'(0));
        chk("t_rel_stall", 128'(r1.stall), 128'(1));
        chk("t_rel_ack", 128'(r1.ack), 128'(0));
        chk("t_rel_err", 128'(r1.err), 128'(0));
        chk("t_rel_grant", 128'(grant), 128'(2'b10));
        repeat (2) tick;
        m1 = '0;
        s = '0;
        tick;
        tick;
        at_neg;
        chk("t_idle", 128'(grant), 128'(2'b00));

        // Ack exactly at the watchdog threshold wins
        tick;
        m0.cyc = 1'b1;
        m0.stb = 1'b1;
        tick;
        repeat (8) tick;
        s.ack = 1'b1;
        at_neg;
        chk("e_ack", 128'(r0.ack), 128'(1));
        tick;
        s.ack = 1'b0;
        at_neg;
        chk("e_no_tmo", 128'(tmo), 128'(0));
        chk("e_grant", 128'(grant), 128'(2'b01));

        // Reset in the middle of a burst
        tick;
        m0.cti = 3'b010;
        s.ack = 1'b1;
        tick;
        rst_n = 1'b0;
        tick;
        at_neg;
        chk("r_bus", 128'(bus), 128'(0));
        chk("r_grant", 128'(grant), 128'(2'b00));
        chk("r_ack0", 128'(r0.ack), 128'(0));
        chk("r_err0", 128'(r0.err), 128'(0));
        chk("r_stall1", 128'(r1.stall), 128'(1));
        tick;
        rst_n = 1'b1;
        m0 = '0;
        s = '0;
        repeat (2) tick;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
